// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory slave: FSM encoding, access
// direction constants and wait-state limits.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ACC_WRITE = 1'b1;
  localparam logic ACC_READ  = 1'b0;

  localparam int WAIT_MAX = 15;
  localparam int WCNT_W   = 4;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, registered read, no reset on contents.
module dmem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mips_data_mem.sv
// CPU data-bus memory slave with programmable wait states, READY/ERR strobes.
// Optional access counters (RD_CNT/WR_CNT) enabled by DMEM_ACCESS_CNT_EN.
module mips_data_mem
  import dmem_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_LOG2  = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CS,
  input  logic                  WR_RD,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] Data_BUS_WRITE,
  output logic [DATA_WIDTH-1:0] Data_BUS_READ,
  output logic                  READY,
  output logic                  ERR
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0]           RD_CNT,
  output logic [31:0]           WR_CNT
`endif
);

  localparam int WS = (WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(1) << (DEPTH_LOG2 + 2);

  state_t                state, state_nx;
  logic [WCNT_W-1:0]     cnt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_sel, off_sel;
  logic [DATA_WIDTH-1:0] wdata_q, rdata;
  logic                  wr_q, valid, commit, we, rd_ok;

  // In IDLE the RAM is addressed straight from the bus so its registered
  // read is ready by the DONE edge even with zero wait states.
  assign addr_sel = (state == IDLE) ? ADDR : addr_q;
  assign off_sel  = addr_sel - BASE_ADDR;
  assign valid    = (addr_sel >= BASE_ADDR) && ({1'b0, off_sel} < SPAN) &&
                    (addr_sel[1:0] == 2'b00);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (CS) state_nx = (WS > 0) ? WAIT : DONE;
      WAIT:    if (cnt <= WCNT_W'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    commit = (state == DONE);
    we     = commit && valid && (wr_q == ACC_WRITE);
    rd_ok  = commit && valid && (wr_q == ACC_READ);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= ACC_READ;
    end else if (state == IDLE && CS) begin
      cnt     <= WCNT_W'(WS);
      addr_q  <= ADDR;
      wdata_q <= Data_BUS_WRITE;
      wr_q    <= WR_RD;
    end else if (state == WAIT) begin
      cnt <= cnt - WCNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      READY         <= 1'b0;
      ERR           <= 1'b0;
      Data_BUS_READ <= '0;
    end else begin
      READY <= commit;
      ERR   <= commit && !valid;
      if (commit && wr_q == ACC_READ)
        Data_BUS_READ <= valid ? rdata : '0;
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RD_CNT <= '0;
      WR_CNT <= '0;
    end else begin
      if (rd_ok) RD_CNT <= RD_CNT + 32'd1;
      if (we)    WR_CNT <= WR_CNT + 32'd1;
    end
  end
`endif

  dmem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .CLK   (CLK),
    .we    (we),
    .addr  (off_sel[DEPTH_LOG2+1:2]),
    .wdata (wdata_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed bench for mips_data_mem: three instances (1, 0, 3 wait states)
// share the bus stimulus; each scenario checks the instance it targets.
module tb_mips_data_mem;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CS = 1'b0;
  logic        WR_RD = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] DW = '0;

  logic [31:0] rdat [3];
  logic [2:0]  ready, err;
`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rdc [3];
  logic [31:0] wrc [3];
`endif

  int errors = 0;
  int checks = 0;

  always #10 CLK = ~CLK;

  mips_data_mem #(.WAIT_STATES(1)) u0 (
    .CLK(CLK), .RST(RST), .CS(CS), .WR_RD(WR_RD), .ADDR(ADDR),
    .Data_BUS_WRITE(DW), .Data_BUS_READ(rdat[0]), .READY(ready[0]), .ERR(err[0])
`ifdef DMEM_ACCESS_CNT_EN
    , .RD_CNT(rdc[0]), .WR_CNT(wrc[0])
`endif
  );

  mips_data_mem #(.WAIT_STATES(0)) u1 (
    .CLK(CLK), .RST(RST), .CS(CS), .WR_RD(WR_RD), .ADDR(ADDR),
    .Data_BUS_WRITE(DW), .Data_BUS_READ(rdat[1]), .READY(ready[1]), .ERR(err[1])
`ifdef DMEM_ACCESS_CNT_EN
    , .RD_CNT(rdc[1]), .WR_CNT(wrc[1])
`endif
  );

  mips_data_mem #(.WAIT_STATES(3)) u2 (
    .CLK(CLK), .RST(RST), .CS(CS), .WR_RD(WR_RD), .ADDR(ADDR),
    .Data_BUS_WRITE(DW), .Data_BUS_READ(rdat[2]), .READY(ready[2]), .ERR(err[2])
`ifdef DMEM_ACCESS_CNT_EN
    , .RD_CNT(rdc[2]), .WR_CNT(wrc[2])
`endif
  );

  // One access: CS high for exactly one sampling edge, then wait for READY
  // of instance d (latency in edges after the sampling edge; 0 = timeout).
  task automatic do_acc(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic er, output logic rdy2);
    @(negedge CLK);
    CS = 1'b1; WR_RD = wr; ADDR = a; DW = wd;
    @(posedge CLK); #1;
    CS = 1'b0;
    lat = 0; rd = 'x; er = 1'bx; rdy2 = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (ready[d]) begin
        lat = i; rd = rdat[d]; er = err[d];
        break;
      end
    end
    @(posedge CLK); #1;
    rdy2 = ready[d];
    repeat (6) @(posedge CLK);
  endtask

  task automatic test_reset();
    for (int t = 0; t < 4; t++) begin
      #20;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if ({ready[d], err[d], rdat[d]} !== 34'd0) begin
          errors++;
          $display("FAIL reset_during[%0d]: got rdy=%b err=%b data=%h want 0/0/0", d, ready[d], err[d], rdat[d]);
        end
      end
    end
    @(negedge CLK); RST = 1'b0;
    repeat (3) @(posedge CLK); #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ready[d], err[d], rdat[d]} !== 34'd0) begin
        errors++;
        $display("FAIL reset_after[%0d]: got rdy=%b err=%b data=%h want 0/0/0", d, ready[d], err[d], rdat[d]);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er, r2;
    do_acc(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, r2);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", er); end
    checks++; if (r2 !== 1'b0) begin errors++; $display("FAIL ready_width: got %b want 0", r2); end
    checks++; if (rdat[0] !== 32'h0) begin errors++; $display("FAIL wr_holds_read: got %h want 0", rdat[0]); end
    do_acc(0, 1'b0, 32'h10, 32'h0, lat, rd, er, r2);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", er); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rd; logic er, r2;
    do_acc(1, 1'b1, 32'hFFC, 32'h12345678, lat, rd, er, r2);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zw_wr_latency: got %0d want 1", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL zw_wr_err: got %b want 0", er); end
    do_acc(1, 1'b0, 32'hFFC, 32'h0, lat, rd, er, r2);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zw_rd_latency: got %0d want 1", lat); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL zw_rd_top: got %h want 12345678", rd); end
    do_acc(1, 1'b0, 32'h10, 32'h0, lat, rd, er, r2);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_rd_0x10: got %h want deadbeef", rd); end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic er, r2;
    do_acc(0, 1'b1, 32'h0, 32'hCAFEF00D, lat, rd, er, r2);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rg_wr0_err: got %b want 0", er); end
    do_acc(0, 1'b1, 32'h1000, 32'h0BAD0BAD, lat, rd, er, r2);
    checks++; if (lat !== 2 || er !== 1'b1) begin errors++; $display("FAIL rg_wr_oor: got lat=%0d err=%b want 2/1", lat, er); end
    do_acc(0, 1'b1, 32'h2, 32'hBAD0BAD0, lat, rd, er, r2);
    checks++; if (lat !== 2 || er !== 1'b1) begin errors++; $display("FAIL rg_wr_misalign: got lat=%0d err=%b want 2/1", lat, er); end
    do_acc(0, 1'b0, 32'h0, 32'h0, lat, rd, er, r2);
    checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL rg_rd0: got %h err=%b want cafef00d/0", rd, er); end
    do_acc(0, 1'b0, 32'h1000, 32'h0, lat, rd, er, r2);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL rg_rd_oor: got %h err=%b want 0/1", rd, er); end
  endtask

  task automatic test_held_cs();
    logic [11:0] mask;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    CS = 1'b1; WR_RD = 1'b0; ADDR = 32'h10;
    mask = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (i == 5) CS = 1'b0;
      mask[i] = ready[0];
    end
    repeat (8) @(posedge CLK); #1;
    checks++; if (mask !== 12'b0000_0010_0100) begin errors++; $display("FAIL held_ready_pattern: got %b want 000000100100", mask); end
    checks++; if (rdat[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL held_data: got %h want deadbeef", rdat[0]); end
`ifdef DMEM_ACCESS_CNT_EN
    checks++; if (rdc[0] !== 32'd2) begin errors++; $display("FAIL held_rd_cnt: got %0d want 2", rdc[0]); end
    checks++; if (wrc[0] !== 32'd0) begin errors++; $display("FAIL held_wr_cnt: got %0d want 0", wrc[0]); end
`endif
  endtask

  task automatic test_mid_reset();
    int lat; logic [31:0] rd; logic er, r2, saw;
    do_acc(2, 1'b1, 32'h20, 32'h11111111, lat, rd, er, r2);
    checks++; if (lat !== 4 || er !== 1'b0) begin errors++; $display("FAIL mr_pre_write: got lat=%0d err=%b want 4/0", lat, er); end
    @(negedge CLK);
    CS = 1'b1; WR_RD = 1'b1; ADDR = 32'h20; DW = 32'hA5A5A5A5;
    @(posedge CLK); #1;
    CS = 1'b0;
    @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    saw = 1'b0;
    repeat (4) begin @(posedge CLK); #1; saw |= ready[2]; end
    @(negedge CLK); RST = 1'b0;
    repeat (8) begin @(posedge CLK); #1; saw |= ready[2]; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL mr_ready_seen: got %b want 0", saw); end
    do_acc(2, 1'b0, 32'h20, 32'h0, lat, rd, er, r2);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL mr_prior_value: got %h want 11111111", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_range();
    test_held_cs();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200 us");
    $fatal(1, "timeout");
  end

endmodule
